// File: rtl/mempool_dma_chunk_splitter.sv
// mempool_dma_chunk_splitter: splits a DMA transfer at ChunkBytes-aligned dst boundaries and routes sub-requests to interleaved backends.
// Optional statistics counters enabled by defining MEMPOOL_DMA_SPLIT_STATS_EN.
module mempool_dma_chunk_splitter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned LenWidth       = 32,
  parameter int unsigned MetaWidth      = 8,
  parameter int unsigned ChunkBytes     = 1024,
  parameter int unsigned NumBackends    = 4,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [AddrWidth-1:0]          req_src_i,
  input  logic [AddrWidth-1:0]          req_dst_i,
  input  logic [LenWidth-1:0]           req_len_i,
  input  logic [MetaWidth-1:0]          req_meta_i,
  output logic [NumBackends-1:0]        out_valid_o,
  input  logic [NumBackends-1:0]        out_ready_i,
  output logic [AddrWidth-1:0]          out_src_o,
  output logic [AddrWidth-1:0]          out_dst_o,
  output logic [$clog2(ChunkBytes):0]   out_len_o,
  output logic [MetaWidth-1:0]          out_meta_o,
  input  logic [NumBackends-1:0]        done_i,
  input  logic [NumBackends-1:0]        backend_idle_i,
  output logic                          backend_idle_o,
  output logic                          trans_complete_o,
  output logic [31:0]                   stat_chunks_o,
  output logic [31:0]                   stat_stalls_o
);
  localparam int unsigned CW = $clog2(ChunkBytes);
  localparam int unsigned SW = NumBackends > 1 ? $clog2(NumBackends) : 1;
  localparam int unsigned OW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PW = $clog2(NumBackends + 1);
  localparam logic [CW:0] CB = (CW+1)'(ChunkBytes);
  typedef enum logic {IDLE, SPLIT} state_e;
  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d, dst_q, dst_d;
  logic [LenWidth-1:0]  rem_q, rem_d;
  logic [MetaWidth-1:0] meta_q, meta_d;
  logic [OW-1:0]        outst_q, outst_d, dec;
  logic                 pending_q, pending_d, idle_q;
  logic [CW:0]          room, chunk;
  logic [SW-1:0]        sel;
  logic [PW-1:0]        done_cnt;
  logic                 accept, issue;
  if (NumBackends > 1) begin : g_sel
    assign sel = dst_q[CW +: SW];
  end else begin : g_nosel
    assign sel = '0;
  end
  assign room        = CB - {1'b0, dst_q[CW-1:0]};
  assign chunk       = (rem_q < LenWidth'(room)) ? rem_q[CW:0] : room;
  assign req_ready_o = state_q == IDLE;
  assign accept      = req_valid_i & req_ready_o;
  assign out_valid_o = (state_q == SPLIT && 32'(outst_q) < MaxOutstanding) ? NumBackends'(1) << sel : '0;
  assign issue       = |(out_valid_o & out_ready_i);
  assign out_src_o   = src_q;
  assign out_dst_o   = dst_q;
  assign out_len_o   = chunk;
  assign out_meta_o  = meta_q;
  assign backend_idle_o = idle_q;
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NumBackends; i++) done_cnt += PW'(done_i[i]);
  end
  // completions beyond what is outstanding are spurious and dropped
  assign dec = (32'(done_cnt) > 32'(outst_q)) ? outst_q : OW'(done_cnt);
  assign outst_d = outst_q + OW'(issue) - dec;
  assign trans_complete_o = pending_q && state_q == IDLE && outst_d == '0;
  assign pending_d = accept | (pending_q & ~trans_complete_o);
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    meta_d  = meta_q;
    if (accept) begin
      src_d   = req_src_i;
      dst_d   = req_dst_i;
      rem_d   = req_len_i;
      meta_d  = req_meta_i;
      state_d = |req_len_i ? SPLIT : IDLE;
    end
    if (issue) begin
      src_d   = src_q + AddrWidth'(chunk);
      dst_d   = dst_q + AddrWidth'(chunk);
      rem_d   = rem_q - LenWidth'(chunk);
      state_d = rem_q == LenWidth'(chunk) ? IDLE : SPLIT;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      meta_q    <= '0;
      outst_q   <= '0;
      pending_q <= 1'b0;
      idle_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      meta_q    <= meta_d;
      outst_q   <= outst_d;
      pending_q <= pending_d;
      idle_q    <= state_q == IDLE && !pending_q && outst_q == '0 && &backend_idle_i;
    end
  end
`ifdef MEMPOOL_DMA_SPLIT_STATS_EN
  logic [31:0] chunks_q, stalls_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chunks_q <= '0;
      stalls_q <= '0;
    end else begin
      chunks_q <= chunks_q + 32'(issue);
      stalls_q <= stalls_q + 32'(state_q == SPLIT && !issue);
    end
  end
  assign stat_chunks_o = chunks_q;
  assign stat_stalls_o = stalls_q;
`else
  assign stat_chunks_o = '0;
  assign stat_stalls_o = '0;
`endif
`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) !((|done_i) && outst_q == '0));
`endif
endmodule
